// File: rtl/fp16_divider.sv
// Iterative FP16 divider: restoring mantissa division at one quotient bit per clock, truncating and flush-to-zero.
// Done pulses 13 cycles after an accepted start (2 for special operands); start is ignored while busy.
module fp16_divider #(
  parameter int          QBITS    = 12,
  parameter logic [15:0] NAN_CODE = 16'h7E00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, SPECIAL = 2'd2, PACK = 2'd3} state_t;

  state_t state, state_nxt;

  logic [15:0]      op_a, op_b;
  logic [11:0]      rem;
  logic [10:0]      dvs;
  logic [10:0]      rem_sub;
  logic [QBITS-1:0] q;
  logic [3:0]       cnt;
  logic             sp_path;
  logic [15:0]      sp_res, sp_res_nxt;
  logic             sp_dbz, sp_dbz_nxt, sp_inv, sp_inv_nxt;
  logic             special_in, ge, sgn;
  logic signed [6:0] e_raw, e_out;
  logic [9:0]       frac;
  logic             pk_ovf, pk_unf;

  function automatic logic is_zero(input logic [4:0] e);
    return e == 5'd0;
  endfunction

  function automatic logic is_inf(input logic [4:0] e, input logic [9:0] m);
    return (e == 5'h1F) && (m == 10'd0);
  endfunction

  function automatic logic is_nan(input logic [4:0] e, input logic [9:0] m);
    return (e == 5'h1F) && (m != 10'd0);
  endfunction

  // Zero (incl. subnormal), infinity and NaN operands all bypass the divide loop.
  always_comb begin
    special_in = (a[14:10] == 5'd0) || (a[14:10] == 5'h1F) ||
                 (b[14:10] == 5'd0) || (b[14:10] == 5'h1F);
  end

  always_comb begin
    sgn        = op_a[15] ^ op_b[15];
    sp_res_nxt = {sgn, 15'h0000};
    sp_dbz_nxt = 1'b0;
    sp_inv_nxt = 1'b0;
    if (is_nan(op_a[14:10], op_a[9:0]) || is_nan(op_b[14:10], op_b[9:0]) ||
        (is_zero(op_a[14:10]) && is_zero(op_b[14:10])) ||
        (is_inf(op_a[14:10], op_a[9:0]) && is_inf(op_b[14:10], op_b[9:0]))) begin
      sp_res_nxt = NAN_CODE;
      sp_inv_nxt = 1'b1;
    end else if (is_inf(op_a[14:10], op_a[9:0])) begin
      sp_res_nxt = {sgn, 5'h1F, 10'h000};
    end else if (is_inf(op_b[14:10], op_b[9:0]) || is_zero(op_a[14:10])) begin
      sp_res_nxt = {sgn, 15'h0000};
    end else begin
      sp_res_nxt = {sgn, 5'h1F, 10'h000};
      sp_dbz_nxt = 1'b1;
    end
  end

  always_comb begin
    ge      = rem >= {1'b0, dvs};
    rem_sub = 11'(rem - {1'b0, dvs});
    e_raw   = $signed({2'b00, op_a[14:10]}) - $signed({2'b00, op_b[14:10]}) + 7'sd15;
    if (q[QBITS-1]) begin
      e_out = e_raw;
      frac  = q[10:1];
    end else begin
      e_out = e_raw - 7'sd1;
      frac  = q[9:0];
    end
    pk_ovf = e_out >= 7'sd31;
    pk_unf = e_out <= 7'sd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special_in ? SPECIAL : DIV;
      DIV:     if (cnt == 4'(QBITS - 1)) state_nxt = PACK;
      SPECIAL: state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a        <= '0;
      op_b        <= '0;
      rem         <= '0;
      dvs         <= '0;
      q           <= '0;
      cnt         <= '0;
      sp_path     <= 1'b0;
      sp_res      <= '0;
      sp_dbz      <= 1'b0;
      sp_inv      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a        <= a;
            op_b        <= b;
            rem         <= {2'b01, a[9:0]};
            dvs         <= {1'b1, b[9:0]};
            q           <= '0;
            cnt         <= '0;
            sp_path     <= special_in;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            invalid     <= 1'b0;
          end
        end
        DIV: begin
          rem <= ge ? {rem_sub, 1'b0} : {rem[10:0], 1'b0};
          q   <= {q[QBITS-2:0], ge};
          cnt <= cnt + 4'd1;
        end
        SPECIAL: begin
          sp_res <= sp_res_nxt;
          sp_dbz <= sp_dbz_nxt;
          sp_inv <= sp_inv_nxt;
        end
        PACK: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (sp_path) begin
            result      <= sp_res;
            div_by_zero <= sp_dbz;
            invalid     <= sp_inv;
          end else begin
            overflow  <= pk_ovf;
            underflow <= pk_unf;
            if (pk_ovf)      result <= {sgn, 5'h1F, 10'h000};
            else if (pk_unf) result <= {sgn, 15'h0000};
            else             result <= {sgn, e_out[4:0], frac};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
